// File: rtl/gfx256_write_combiner.sv
// gfx256_write_combiner: merges renderer pixel writes to one 32-byte strip
// and issues a single 256-bit Wishbone write per strip.
module gfx256_write_combiner #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         write_i,
    input  logic [26:0]  render_addr_i,
    input  logic [31:0]  render_sel_i,
    input  logic [255:0] render_dat_i,
    output logic         ack_o,
    input  logic         flush_i,
    output logic         idle_o,
    output logic         wbm_cyc_o,
    output logic         wbm_stb_o,
    output logic         wbm_we_o,
    output logic [26:0]  wbm_adr_o,
    output logic [31:0]  wbm_sel_o,
    output logic [255:0] wbm_dat_o,
    input  logic         wbm_ack_i
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_HOLD,
        S_FLUSH,
        S_FLUSH_MISS
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t         state_q, state_d;
    logic [26:0]    line_addr_q, line_addr_d;
    logic [31:0]    line_sel_q, line_sel_d;
    logic [255:0]   line_dat_q, line_dat_d;
    logic           valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           ack_q, ack_d;
    logic           cyc_q, cyc_d;
    logic           we_q, we_d;
    logic [26:0]    adr_q, adr_d;
    logic [31:0]    sel_q, sel_d;
    logic [255:0]   dat_q, dat_d;

    logic [255:0]   merged_dat;
    logic           hit;
    logic           line_full;
    logic           load;
    logic           start_bus;

    assign hit       = valid_q && (render_addr_i == line_addr_q);
    assign line_full = &line_sel_q;

    always_comb begin
        merged_dat = line_dat_q;
        for (int b = 0; b < 32; b++) begin
            if (render_sel_i[b]) begin
                merged_dat[b*8 +: 8] = render_dat_i[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        line_sel_d  = line_sel_q;
        line_dat_d  = line_dat_q;
        valid_d     = valid_q;
        cnt_d       = cnt_q;
        ack_d       = 1'b0;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        load        = 1'b0;
        start_bus   = 1'b0;

        unique case (state_q)
            S_EMPTY: begin
                load = write_i;
            end
            S_HOLD: begin
                if (write_i && hit) begin
                    line_sel_d = line_sel_q | render_sel_i;
                    line_dat_d = merged_dat;
                    ack_d      = 1'b1;
                    cnt_d      = '0;
                end else if (write_i) begin
                    state_d   = S_FLUSH_MISS;
                    start_bus = 1'b1;
                end else if (flush_i || line_full || cnt_q == CNT_LAST) begin
                    state_d   = S_FLUSH;
                    start_bus = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FLUSH: begin
                if (wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    valid_d = 1'b0;
                    state_d = S_EMPTY;
                    load    = write_i;
                end else if (write_i) begin
                    // renderer holds its inputs, so the write waits as pending
                    state_d = S_FLUSH_MISS;
                end
            end
            S_FLUSH_MISS: begin
                if (wbm_ack_i) begin
                    cyc_d = 1'b0;
                    we_d  = 1'b0;
                    load  = 1'b1;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        if (load) begin
            line_addr_d = render_addr_i;
            line_sel_d  = render_sel_i;
            line_dat_d  = merged_dat;
            valid_d     = 1'b1;
            cnt_d       = '0;
            ack_d       = 1'b1;
            state_d     = S_HOLD;
        end

        if (start_bus) begin
            cyc_d = 1'b1;
            we_d  = 1'b1;
            adr_d = line_addr_q;
            sel_d = line_sel_q;
            dat_d = line_dat_q;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_EMPTY;
            line_addr_q <= '0;
            line_sel_q  <= '0;
            line_dat_q  <= '0;
            valid_q     <= 1'b0;
            cnt_q       <= '0;
            ack_q       <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            line_sel_q  <= line_sel_d;
            line_dat_q  <= line_dat_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
        end
    end

    assign ack_o     = ack_q;
    assign idle_o    = (state_q == S_EMPTY);
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_sel_o = sel_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_gfx256_write_combiner.sv
// Bench for gfx256_write_combiner: directed scenarios plus random strip
// writes compared against a byte-level combining model.
module tb_gfx256_write_combiner;

    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [26:0]  adr;
        logic [31:0]  sel;
        logic [255:0] dat;
        logic         we;
    } txn_t;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         write_i;
    logic [26:0]  render_addr_i;
    logic [31:0]  render_sel_i;
    logic [255:0] render_dat_i;
    logic         ack_o;
    logic         flush_i;
    logic         idle_o;
    logic         wbm_cyc_o;
    logic         wbm_stb_o;
    logic         wbm_we_o;
    logic [26:0]  wbm_adr_o;
    logic [31:0]  wbm_sel_o;
    logic [255:0] wbm_dat_o;
    logic         wbm_ack_i;

    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;

    txn_t bus_q[$];
    txn_t exp_q[$];
    int   bus_wait = 0;
    int   wait_cnt = 0;
    int   cyc_start = 0;
    int   ack_at = 0;
    logic prev_cyc = 1'b0;

    logic [26:0]  m_addr;
    logic [31:0]  m_sel;
    logic [255:0] m_dat;
    bit           m_valid = 0;

    gfx256_write_combiner #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .write_i       (write_i),
        .render_addr_i (render_addr_i),
        .render_sel_i  (render_sel_i),
        .render_dat_i  (render_dat_i),
        .ack_o         (ack_o),
        .flush_i       (flush_i),
        .idle_o        (idle_o),
        .wbm_cyc_o     (wbm_cyc_o),
        .wbm_stb_o     (wbm_stb_o),
        .wbm_we_o      (wbm_we_o),
        .wbm_adr_o     (wbm_adr_o),
        .wbm_sel_o     (wbm_sel_o),
        .wbm_dat_o     (wbm_dat_o),
        .wbm_ack_i     (wbm_ack_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Wishbone slave: acks after bus_wait wait states, logs each write
    initial begin
        wbm_ack_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (wbm_ack_i || rst_i) begin
                wbm_ack_i = 1'b0;
                wait_cnt  = 0;
            end else if (wbm_cyc_o && wbm_stb_o) begin
                if (!prev_cyc) cyc_start = cyc_n;
                if (wait_cnt >= bus_wait) begin
                    wbm_ack_i = 1'b1;
                    ack_at    = cyc_n + 1;
                    bus_q.push_back('{adr: wbm_adr_o, sel: wbm_sel_o,
                                      dat: wbm_dat_o, we: wbm_we_o});
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
            prev_cyc = wbm_cyc_o;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] bmask(input logic [31:0] s);
        logic [255:0] m;
        for (int i = 0; i < 32; i++) m[i*8 +: 8] = {8{s[i]}};
        return m;
    endfunction

    // Reference model: a strip buffer in byte terms
    task automatic model_flush();
        if (m_valid) exp_q.push_back('{adr: m_addr, sel: m_sel, dat: m_dat, we: 1'b1});
        m_valid = 0;
    endtask

    task automatic model_write(input logic [26:0] a, input logic [31:0] s,
                               input logic [255:0] d);
        if (m_valid && a != m_addr) model_flush();
        if (!m_valid) begin
            m_valid = 1;
            m_addr  = a;
            m_sel   = '0;
            m_dat   = '0;
        end
        for (int b = 0; b < 32; b++) begin
            if (s[b]) m_dat[b*8 +: 8] = d[b*8 +: 8];
        end
        m_sel = m_sel | s;
        if (&m_sel) model_flush();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [26:0] a, input logic [31:0] s,
                            input logic [255:0] d, output int t0, output int ta);
        int n;
        render_addr_i = a;
        render_sel_i  = s;
        render_dat_i  = d;
        write_i       = 1'b1;
        t0 = cyc_n;
        n  = 0;
        step();
        write_i = 1'b0;
        while (ack_o !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        ta = cyc_n;
        vectors++;
        if (ack_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_wait: ack_o=%b after %0d cycles, required 1", ack_o, n);
        end
        step();
        vectors++;
        if (ack_o !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_pulse: ack_o=%b one cycle after ack, required 0", ack_o);
        end
        render_addr_i = 27'($urandom);
        render_sel_i  = $urandom;
        render_dat_i  = rand256();
    endtask

    task automatic wait_bus(input int bound);
        int n;
        n = 0;
        while (bus_q.size() == 0 && n < bound) begin
            step();
            n++;
        end
        vectors++;
        if (bus_q.size() == 0) begin
            miscompares++;
            $display("FAIL bus_wait: no bus write after %0d cycles, required 1", n);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; write_i = 1'b0; flush_i = 1'b0;
        render_addr_i = '0; render_sel_i = '0; render_dat_i = '0;
        repeat (3) step();
        vectors++;
        if (ack_o !== 1'b0 || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: ack=%b cyc=%b stb=%b, required 0 0 0",
                     ack_o, wbm_cyc_o, wbm_stb_o);
        end
        vectors++;
        if (wbm_we_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_we: we=%b, required 0", wbm_we_o);
        end
        vectors++;
        if (wbm_adr_o !== 27'h0 || wbm_sel_o !== 32'h0 || wbm_dat_o !== 256'h0) begin
            miscompares++;
            $display("FAIL reset_bus: adr=%h sel=%h dat=%h, required all 0",
                     wbm_adr_o, wbm_sel_o, wbm_dat_o);
        end
        vectors++;
        if (idle_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_idle: idle_o=%b, required 1", idle_o);
        end
        rst_i = 1'b0;
        step();
        vectors++;
        if (idle_o !== 1'b1 || wbm_cyc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: idle=%b cyc=%b, required 1 0", idle_o, wbm_cyc_o);
        end
    endtask

    task automatic test_timeout();
        logic [255:0] d, gd;
        txn_t got, exp;
        int t0, ta;
        bus_q.delete(); exp_q.delete();
        bus_wait = 1;
        d = rand256();
        d[31:0] = 32'h44332211;
        model_write(27'h0000100, 32'h0000000F, d);
        do_write(27'h0000100, 32'h0000000F, d, t0, ta);
        vectors++;
        if (ta - t0 != 1) begin
            miscompares++;
            $display("FAIL empty_latency: ack after %0d cycles, required 1", ta - t0);
        end
        vectors++;
        if (idle_o !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_busy: idle_o=%b with line held, required 0", idle_o);
        end
        model_flush();
        wait_bus(100);
        vectors++;
        if (idle_o !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_after: idle_o=%b after bus ack, required 1", idle_o);
        end
        if (bus_q.size() != 0) begin
            got = bus_q.pop_front();
            exp = exp_q.pop_front();
            gd  = got.dat & bmask(got.sel);
            vectors++;
            if (cyc_start - ta != TIMEOUT) begin
                miscompares++;
                $display("FAIL timeout_delay: cyc %0d cycles after ack, required %0d",
                         cyc_start - ta, TIMEOUT);
            end
            vectors++;
            if (got.adr !== 27'h0000100 || got.sel !== 32'h0000000F || got.we !== 1'b1) begin
                miscompares++;
                $display("FAIL timeout_hdr: adr=%h sel=%h we=%b, required 0000100 0000000f 1",
                         got.adr, got.sel, got.we);
            end
            vectors++;
            if (gd[31:0] !== 32'h44332211 || gd !== (exp.dat & bmask(exp.sel))) begin
                miscompares++;
                $display("FAIL timeout_dat: dat=%h, required %h", gd, exp.dat & bmask(exp.sel));
            end
        end
    endtask

    task automatic test_hit_merge();
        logic [255:0] d1, d2, d3, gd;
        txn_t got, exp;
        int t0, ta;
        bus_q.delete(); exp_q.delete();
        d1 = rand256(); d1[23:16] = 8'hAA;
        d2 = rand256();
        d3 = rand256(); d3[23:16] = 8'hBB;
        model_write(27'h0000100, 32'h0000000F, d1);
        do_write(27'h0000100, 32'h0000000F, d1, t0, ta);
        model_write(27'h0000100, 32'h000000F0, d2);
        do_write(27'h0000100, 32'h000000F0, d2, t0, ta);
        vectors++;
        if (ta - t0 != 1) begin
            miscompares++;
            $display("FAIL hit_latency: ack after %0d cycles, required 1", ta - t0);
        end
        model_write(27'h0000100, 32'h00000004, d3);
        do_write(27'h0000100, 32'h00000004, d3, t0, ta);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        model_flush();
        wait_bus(50);
        if (bus_q.size() != 0) begin
            got = bus_q.pop_front();
            exp = exp_q.pop_front();
            gd  = got.dat;
            vectors++;
            if (got.sel !== 32'h000000FF || got.adr !== 27'h0000100) begin
                miscompares++;
                $display("FAIL merge_sel: adr=%h sel=%h, required 0000100 000000ff",
                         got.adr, got.sel);
            end
            vectors++;
            if (gd[23:16] !== 8'hBB) begin
                miscompares++;
                $display("FAIL merge_overlap: byte2=%h, required bb", gd[23:16]);
            end
            vectors++;
            if ((got.dat & bmask(got.sel)) !== (exp.dat & bmask(exp.sel))) begin
                miscompares++;
                $display("FAIL merge_dat: dat=%h, required %h",
                         got.dat & bmask(got.sel), exp.dat & bmask(exp.sel));
            end
        end
    endtask

    task automatic test_miss();
        logic [255:0] d1, d2;
        txn_t got, exp;
        int t0, ta;
        bus_q.delete(); exp_q.delete();
        bus_wait = 3;
        d1 = rand256();
        d2 = rand256();
        model_write(27'h0000100, 32'h0000000F, d1);
        do_write(27'h0000100, 32'h0000000F, d1, t0, ta);
        model_write(27'h0000101, 32'h00000001, d2);
        do_write(27'h0000101, 32'h00000001, d2, t0, ta);
        vectors++;
        if (cyc_start != t0 + 1) begin
            miscompares++;
            $display("FAIL miss_cyc: cyc %0d cycles after write, required 1", cyc_start - t0);
        end
        vectors++;
        if (ta != ack_at || ta - cyc_start != 4) begin
            miscompares++;
            $display("FAIL miss_ack: ack_o at %0d (bus ack sampled %0d, cyc %0d), required %0d",
                     ta, ack_at, cyc_start, cyc_start + 4);
        end
        if (bus_q.size() != 0) begin
            got = bus_q.pop_front();
            exp = exp_q.pop_front();
            vectors++;
            if (got.adr !== 27'h0000100 || got.sel !== exp.sel ||
                (got.dat & bmask(got.sel)) !== (exp.dat & bmask(exp.sel))) begin
                miscompares++;
                $display("FAIL miss_old_line: adr=%h sel=%h, required 0000100 %h",
                         got.adr, got.sel, exp.sel);
            end
        end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        model_flush();
        wait_bus(50);
        if (bus_q.size() != 0) begin
            got = bus_q.pop_front();
            exp = exp_q.pop_front();
            vectors++;
            if (got.adr !== 27'h0000101 || got.sel !== 32'h00000001 ||
                (got.dat & bmask(got.sel)) !== (exp.dat & bmask(exp.sel))) begin
                miscompares++;
                $display("FAIL miss_new_line: adr=%h sel=%h dat=%h, required 0000101 00000001 %h",
                         got.adr, got.sel, got.dat & bmask(got.sel), exp.dat & bmask(exp.sel));
            end
        end
    endtask

    task automatic test_full_line();
        logic [255:0] d;
        txn_t got, exp;
        int t0, ta;
        bus_q.delete(); exp_q.delete();
        bus_wait = 1;
        for (int i = 0; i < 8; i++) begin
            d = rand256();
            model_write(27'h0000200, 32'h0000000F << (4 * i), d);
            do_write(27'h0000200, 32'h0000000F << (4 * i), d, t0, ta);
        end
        vectors++;
        if (wbm_cyc_o !== 1'b1) begin
            miscompares++;
            $display("FAIL full_start: cyc=%b the cycle after last ack, required 1", wbm_cyc_o);
        end
        wait_bus(50);
        if (bus_q.size() != 0) begin
            got = bus_q.pop_front();
            exp = exp_q.pop_front();
            vectors++;
            if (cyc_start != ta + 1) begin
                miscompares++;
                $display("FAIL full_delay: cyc %0d cycles after ack, required 1", cyc_start - ta);
            end
            vectors++;
            if (got.sel !== 32'hFFFFFFFF || got.adr !== 27'h0000200 || got.dat !== exp.dat) begin
                miscompares++;
                $display("FAIL full_line: adr=%h sel=%h dat=%h, required 0000200 ffffffff %h",
                         got.adr, got.sel, got.dat, exp.dat);
            end
        end
    endtask

    task automatic test_flush();
        logic [255:0] d;
        txn_t got, exp;
        int t0, ta, cycs, busy;
        bus_q.delete(); exp_q.delete();
        d = rand256();
        model_write(27'h0000050, 32'h00F0F00F, d);
        do_write(27'h0000050, 32'h00F0F00F, d, t0, ta);
        step();
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        vectors++;
        if (wbm_cyc_o !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_start: cyc=%b one cycle after flush_i, required 1", wbm_cyc_o);
        end
        model_flush();
        wait_bus(50);
        if (bus_q.size() != 0) begin
            got = bus_q.pop_front();
            exp = exp_q.pop_front();
            vectors++;
            if (got.adr !== exp.adr || got.sel !== exp.sel ||
                (got.dat & bmask(got.sel)) !== (exp.dat & bmask(exp.sel))) begin
                miscompares++;
                $display("FAIL flush_line: adr=%h sel=%h, required %h %h",
                         got.adr, got.sel, exp.adr, exp.sel);
            end
        end
        cycs = 0;
        busy = 0;
        flush_i = 1'b1;
        repeat (20) begin
            step();
            if (wbm_cyc_o !== 1'b0) cycs++;
            if (idle_o !== 1'b1) busy++;
        end
        flush_i = 1'b0;
        vectors++;
        if (cycs != 0 || busy != 0) begin
            miscompares++;
            $display("FAIL flush_empty: %0d cyc cycles, %0d non-idle cycles, required 0 0",
                     cycs, busy);
        end
    endtask

    task automatic test_random();
        logic [26:0]  pool [3];
        logic [26:0]  a;
        logic [31:0]  s;
        logic [255:0] d;
        txn_t got, exp;
        int t0, ta, n, k;
        pool[0] = 27'h0000300;
        pool[1] = 27'h0000301;
        pool[2] = 27'h7ABCDEF;
        bus_q.delete(); exp_q.delete();
        for (int i = 0; i < 60; i++) begin
            bus_wait = $urandom_range(0, 3);
            a = pool[$urandom_range(0, 2)];
            k = $urandom_range(0, 3);
            case (k)
                0: s = $urandom;
                1: s = 32'h1 << $urandom_range(0, 31);
                2: s = 32'hFFFFFFFF;
                default: s = 32'hF << (4 * $urandom_range(0, 7));
            endcase
            d = rand256();
            model_write(a, s, d);
            do_write(a, s, d, t0, ta);
            repeat ($urandom_range(0, 3)) step();
        end
        flush_i = 1'b1;
        n = 0;
        step();
        while (!(idle_o === 1'b1 && wbm_cyc_o === 1'b0) && n < 300) begin
            step();
            n++;
        end
        flush_i = 1'b0;
        model_flush();
        vectors++;
        if (n >= 300) begin
            miscompares++;
            $display("FAIL rand_drain: not idle after %0d cycles, required idle", n);
        end
        vectors++;
        if (bus_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_count: %0d bus writes, required %0d", bus_q.size(), exp_q.size());
        end
        while (bus_q.size() != 0 && exp_q.size() != 0) begin
            got = bus_q.pop_front();
            exp = exp_q.pop_front();
            vectors++;
            if (got.adr !== exp.adr || got.sel !== exp.sel || got.we !== 1'b1 ||
                (got.dat & bmask(got.sel)) !== (exp.dat & bmask(exp.sel))) begin
                miscompares++;
                $display("FAIL rand_txn: adr=%h sel=%h dat=%h, required %h %h %h",
                         got.adr, got.sel, got.dat & bmask(got.sel),
                         exp.adr, exp.sel, exp.dat & bmask(exp.sel));
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0, ta, acks, cycs;
        bus_q.delete(); exp_q.delete();
        bus_wait = 20;
        do_write(27'h0000400, 32'h000000FF, rand256(), t0, ta);
        render_addr_i = 27'h0000401;
        render_sel_i  = 32'h00000001;
        write_i = 1'b1;
        step();
        write_i = 1'b0;
        vectors++;
        if (wbm_cyc_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_cyc: cyc=%b after miss write, required 1", wbm_cyc_o);
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        vectors++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || idle_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: cyc=%b stb=%b idle=%b, required 0 0 1",
                     wbm_cyc_o, wbm_stb_o, idle_o);
        end
        acks = 0;
        cycs = 0;
        repeat (25) begin
            step();
            if (ack_o !== 1'b0) acks++;
            if (wbm_cyc_o !== 1'b0) cycs++;
        end
        vectors++;
        if (acks != 0 || cycs != 0 || bus_q.size() != 0) begin
            miscompares++;
            $display("FAIL mid_after: %0d acks %0d cyc cycles %0d bus writes, required 0 0 0",
                     acks, cycs, bus_q.size());
        end
        m_valid = 0;
        exp_q.delete();
        bus_wait = 0;
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_hit_merge();
        test_miss();
        test_full_line();
        test_flush();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
